// File: rtl/vga_ctrl.sv
// 640x480@60 VGA timing generator: free-running line/frame counters, sync decode,
// early pixel request toward the registered pattern stage, and active-region gating of rgb.
module vga_ctrl #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_VALID  = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_VALID  = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned PIX_LAT  = 1,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_data_req,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_valid,
  output logic [15:0] rgb,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int unsigned H_ACT   = H_SYNC + H_BACK;
  localparam int unsigned V_ACT   = V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_LO   = 10'(H_ACT);
  localparam logic [9:0] H_ACT_HI   = 10'(H_ACT + H_VALID);
  localparam logic [9:0] V_ACT_LO   = 10'(V_ACT);
  localparam logic [9:0] V_ACT_HI   = 10'(V_ACT + V_VALID);
  // Requests lead the display column by PIX_LAT so returned data lines up with rgb.
  localparam logic [9:0] REQ_LO     = 10'(H_ACT - PIX_LAT);
  localparam logic [9:0] REQ_HI     = 10'(H_ACT + H_VALID - PIX_LAT);

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       line_end;
  logic       frame_end;
  logic       v_active;
  logic       h_active;
  logic       h_request;

  assign line_end  = (cnt_h == H_LAST);
  assign frame_end = line_end && (cnt_v == V_LAST);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h <= '0;
    end else if (line_end) begin
      cnt_h <= '0;
    end else begin
      cnt_h <= cnt_h + 10'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_v <= '0;
    end else if (line_end) begin
      if (cnt_v == V_LAST) begin
        cnt_v <= '0;
      end else begin
        cnt_v <= cnt_v + 10'd1;
      end
    end
  end

  // Registered so the pulse coincides with counters reading (0,0); stays low out of reset.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= frame_end;
      if (frame_end) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  assign hsync = (cnt_h < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
  assign vsync = (cnt_v < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;

  assign v_active  = (cnt_v >= V_ACT_LO) && (cnt_v < V_ACT_HI);
  assign h_active  = (cnt_h >= H_ACT_LO) && (cnt_h < H_ACT_HI);
  assign h_request = (cnt_h >= REQ_LO) && (cnt_h < REQ_HI);

  always_comb begin
    pix_data_req = h_request && v_active;
    pix_x        = 10'h3FF;
    pix_y        = 10'h3FF;
    if (pix_data_req) begin
      pix_x = cnt_h - REQ_LO;
      pix_y = cnt_v - V_ACT_LO;
    end
  end

  assign rgb_valid = h_active && v_active;
  assign rgb       = rgb_valid ? pix_data : 16'h0000;

endmodule

// File: doc/vga_ctrl.md
Name: vga_ctrl

Overview:
- VGA timing generator for a 640x480@60 Hz display. It sits directly upstream of the pixel-pattern stage.
- Runs free horizontal and vertical counters and produces hsync/vsync.
- Issues pix_x/pix_y early enough for the registered pixel-pattern stage to return pix_data in time.
- Gates the returned pix_data onto the rgb output during the active region only.

Parameters:
H_SYNC, 96, hsync pulse width (pixel clocks)
H_BACK, 48, horizontal back porch
H_VALID, 640, active pixels per line
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch
V_VALID, 480, active lines
V_FRONT, 10, vertical front porch
PIX_LAT, 1, clocks from pix_x/pix_y to matching pix_data (0..4)
SYNC_POL, 0, active level of hsync/vsync

Ports:
vga_clk  in  1  pixel clock, 25 MHz
sys_rst_n  in  1  asynchronous reset, active low
pix_data  in  16  RGB565 from the pixel-pattern stage, PIX_LAT clocks after request
pix_x  out  10  requested X coordinate; 10'h3FF outside the request window
pix_y  out  10  requested Y coordinate; 10'h3FF outside the request window
pix_data_req  out  1  high while pix_x/pix_y are valid
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
rgb_valid  out  1  high during the active display region
rgb  out  16  pix_data when rgb_valid, else 16'h0000
frame_start  out  1  one-cycle pulse at the first clock of each frame
frame_cnt  out  8  completed-frame counter, wraps

Behaviour:
- Derived totals: H_TOTAL = sum of the four H_* parameters = 800; V_TOTAL = sum of the four V_* parameters = 525.
- Derived start points: H_ACT = H_SYNC+H_BACK = 144; V_ACT = V_SYNC+V_BACK = 35.
- Counters:
  - cnt_h (10 b) counts 0..H_TOTAL-1, wraps to 0.
  - cnt_v (10 b) increments only when cnt_h==H_TOTAL-1, wraps to 0 after V_TOTAL-1.
  - Both reset to 0 asynchronously.
- hsync = SYNC_POL when cnt_h < H_SYNC, else ~SYNC_POL.
- vsync = SYNC_POL when cnt_v < V_SYNC, else ~SYNC_POL.
- hsync and vsync are combinational decodes of the registered counters.
- rgb_valid = (H_ACT <= cnt_h < H_ACT+H_VALID) && (V_ACT <= cnt_v < V_ACT+V_VALID).
- rgb = rgb_valid ? pix_data : 0. There is no added register, so rgb is valid in the same cycle as rgb_valid.
- Request window:
  - pix_data_req = (H_ACT-PIX_LAT <= cnt_h < H_ACT+H_VALID-PIX_LAT) && vertical active.
  - pix_x = cnt_h-(H_ACT-PIX_LAT) when pix_data_req, else 10'h3FF.
  - pix_y = cnt_v-V_ACT when pix_data_req, else 10'h3FF.
  - Effect: data for pix_x=N arrives exactly at rgb column N.
- frame_start: registered pulse, set on the clock where cnt_h==H_TOTAL-1 && cnt_v==V_TOTAL-1. It is therefore high while the counters read (0,0), except immediately after reset, where it stays 0.
- frame_cnt: increments by 1 on the same condition as frame_start; 8-bit wrap 255 -> 0.
- Values during reset (sys_rst_n=0):
  - Counters and frame_cnt are 0; frame_start=0; rgb_valid=0; rgb=0; pix_data_req=0.
  - pix_x=pix_y=10'h3FF.
  - hsync=vsync=SYNC_POL.
- Reset asserted mid-frame:
  - All state clears immediately.
  - After release, timing restarts from cnt_h=0, cnt_v=0 with no partial-frame artefacts.
- pix_data is ignored (rgb=0) outside rgb_valid, whatever its value.
- Parameter changes alter only the timing constants. PIX_LAT > H_ACT is illegal.

Test Plan:
1. Release reset, default params -> hsync low for 96 clocks then high for 704; line period exactly 800 clocks; vsync low for the first 1600 clocks of each frame; frame period 420000 clocks.
2. Count to line cnt_v=35 -> pix_data_req rises at cnt_h=143 with pix_x=0, pix_y=0. At cnt_h=782, pix_x=639. At cnt_h=783, pix_x=3FF and pix_data_req=0. Line cnt_v=514 gives pix_y=479; line 515 has no requests.
3. Hold pix_data=16'hF800 constant -> rgb=F800 exactly for cnt_h 144..783 within lines 35..514, 0 elsewhere; 307200 valid pixels per frame.
4. Connect a model with 1-clock registered latency returning {pix_y[5:0],pix_x[9:0]} -> every rgb_valid cycle shows rgb matching (cnt_h-144, cnt_v-35). Repeat with PIX_LAT=3 and a 3-stage model: same result.
5. Run 257 frames -> frame_start pulses once per 420000 clocks and never right after reset; frame_cnt goes 0->255->0->1.
6. Drop sys_rst_n at cnt_h=300, cnt_v=100 for 5 clocks -> outputs immediately take their reset values, frame_cnt=0. First hsync edge after release occurs 96 clocks later.
